// File: rtl/mmul_seq_ctrl_if.sv
// Command and array-control bundle between the front-end, the sequencer and the PE-grid feed/drain logic.
// master drives commands and observes strobes; slave is the sequencer.
interface mmul_seq_ctrl_if #(
  parameter int ADDR_WIDTH = 64
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_a_addr;
  logic [ADDR_WIDTH-1:0] cmd_b_addr;
  logic [ADDR_WIDTH-1:0] cmd_c_addr;
  logic                  feed_valid;
  logic                  feed_last;
  logic [ADDR_WIDTH-1:0] feed_a_addr;
  logic [ADDR_WIDTH-1:0] feed_b_addr;
  logic                  acc_clear;
  logic                  drain_en;
  logic [ADDR_WIDTH-1:0] drain_addr;
  logic                  busy;
  logic                  done;

  modport master (
    output cmd_valid, cmd_op, cmd_a_addr, cmd_b_addr, cmd_c_addr,
    input  cmd_ready, feed_valid, feed_last, feed_a_addr, feed_b_addr,
    input  acc_clear, drain_en, drain_addr, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a_addr, cmd_b_addr, cmd_c_addr,
    output cmd_ready, feed_valid, feed_last, feed_a_addr, feed_b_addr,
    output acc_clear, drain_en, drain_addr, busy, done
  );
endinterface

// File: rtl/mmul_seq_ctrl.sv
// Systolic-array sequencer: one command at a time through FEED, SETTLE, optional DRAIN and DONE.
// Strobes appear 1 cycle after the handshake; cmd_ready is held low for the whole command.
module mmul_seq_ctrl #(
  parameter int SYS_ARRAY_SIZE = 2,
  parameter int ADDR_WIDTH     = 64
) (
  input logic            clk,
  input logic            rst_n,
  mmul_seq_ctrl_if.slave bus
);
  localparam int T_C = SYS_ARRAY_SIZE;
  localparam int T_D = 2 * SYS_ARRAY_SIZE;
  localparam int CW  = $clog2(T_D) + 1;
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(SYS_ARRAY_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_SETTLE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  op_q;
  logic [ADDR_WIDTH-1:0] c_base;
  logic                  pending_acc, pending_acc_n;
  logic                  hs;

  logic                  feed_valid_q, feed_valid_n;
  logic                  feed_last_q, feed_last_n;
  logic                  acc_clear_q, acc_clear_n;
  logic                  drain_en_q, drain_en_n;
  logic                  done_q, done_n;
  logic [ADDR_WIDTH-1:0] feed_a_q, feed_a_n;
  logic [ADDR_WIDTH-1:0] feed_b_q, feed_b_n;
  logic [ADDR_WIDTH-1:0] drain_addr_q, drain_addr_n;

  assign hs = bus.cmd_valid && (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic also computes next-cycle outputs so every strobe leaves a flop.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt + CW'(1);
    pending_acc_n = pending_acc;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (hs) state_n = S_FEED;
      end
      S_FEED:   if (cnt == CW'(T_C - 1)) state_n = S_SETTLE;
      S_SETTLE: if (cnt == CW'(T_D - 1)) state_n = op_q ? S_DONE : S_DRAIN;
      S_DRAIN:  if (cnt == CW'(T_C - 1)) state_n = S_DONE;
      S_DONE: begin
        state_n       = S_IDLE;
        pending_acc_n = op_q;
      end
      default:  state_n = S_IDLE;
    endcase
    if (state_n != state) cnt_n = '0;

    feed_valid_n = (state_n == S_FEED);
    feed_last_n  = (state_n == S_FEED) && (cnt_n == CW'(T_C - 1));
    acc_clear_n  = (state_n == S_FEED) && (cnt_n == '0) && !pending_acc;
    drain_en_n   = (state_n == S_DRAIN);
    done_n       = (state_n == S_DONE);

    feed_a_n = '0;
    feed_b_n = '0;
    if (hs) begin
      feed_a_n = bus.cmd_a_addr;
      feed_b_n = bus.cmd_b_addr;
    end else if (state == S_FEED && state_n == S_FEED) begin
      feed_a_n = feed_a_q + STEP;
      feed_b_n = feed_b_q + STEP;
    end

    drain_addr_n = '0;
    if (state == S_SETTLE && state_n == S_DRAIN) drain_addr_n = c_base;
    else if (state == S_DRAIN && state_n == S_DRAIN) drain_addr_n = drain_addr_q + STEP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= 1'b0;
      c_base       <= '0;
      pending_acc  <= 1'b0;
      feed_valid_q <= 1'b0;
      feed_last_q  <= 1'b0;
      acc_clear_q  <= 1'b0;
      drain_en_q   <= 1'b0;
      done_q       <= 1'b0;
      feed_a_q     <= '0;
      feed_b_q     <= '0;
      drain_addr_q <= '0;
    end else begin
      if (hs) begin
        op_q   <= bus.cmd_op;
        c_base <= bus.cmd_c_addr;
      end
      pending_acc  <= pending_acc_n;
      feed_valid_q <= feed_valid_n;
      feed_last_q  <= feed_last_n;
      acc_clear_q  <= acc_clear_n;
      drain_en_q   <= drain_en_n;
      done_q       <= done_n;
      feed_a_q     <= feed_a_n;
      feed_b_q     <= feed_b_n;
      drain_addr_q <= drain_addr_n;
    end
  end

  assign bus.cmd_ready   = (state == S_IDLE);
  assign bus.busy        = (state != S_IDLE);
  assign bus.feed_valid  = feed_valid_q;
  assign bus.feed_last   = feed_last_q;
  assign bus.feed_a_addr = feed_a_q;
  assign bus.feed_b_addr = feed_b_q;
  assign bus.acc_clear   = acc_clear_q;
  assign bus.drain_en    = drain_en_q;
  assign bus.drain_addr  = drain_addr_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_mmul_seq_ctrl.sv
// Directed bench for mmul_seq_ctrl with N=2; cycle numbers count from the handshake cycle (cycle 0).
module tb_mmul_seq_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mmul_seq_ctrl_if #(.ADDR_WIDTH(64)) bus ();

  mmul_seq_ctrl #(.SYS_ARRAY_SIZE(2), .ADDR_WIDTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        s_fv [0:31];
  logic        s_fl [0:31];
  logic        s_ac [0:31];
  logic        s_de [0:31];
  logic        s_dn [0:31];
  logic        s_rd [0:31];
  logic        s_bz [0:31];
  logic [63:0] s_fa [0:31];
  logic [63:0] s_fb [0:31];
  logic [63:0] s_da [0:31];

  task automatic sample(input int c);
    s_fv[c] = bus.feed_valid;
    s_fl[c] = bus.feed_last;
    s_ac[c] = bus.acc_clear;
    s_de[c] = bus.drain_en;
    s_dn[c] = bus.done;
    s_rd[c] = bus.cmd_ready;
    s_bz[c] = bus.busy;
    s_fa[c] = bus.feed_a_addr;
    s_fb[c] = bus.feed_b_addr;
    s_da[c] = bus.drain_addr;
  endtask

  // Offers one command at a negedge (cycle 0) and records cycles 1..ncyc.
  task automatic issue(input logic op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] cc, input int ncyc);
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = op;
    bus.cmd_a_addr = a;
    bus.cmd_b_addr = b;
    bus.cmd_c_addr = cc;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (i == 1) bus.cmd_valid = 1'b0;
      sample(i);
    end
  endtask

  task automatic test_reset;
    logic [6:0] got;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 1'b0;
    bus.cmd_a_addr = '0;
    bus.cmd_b_addr = '0;
    bus.cmd_c_addr = '0;
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    got = {bus.feed_valid, bus.feed_last, bus.acc_clear, bus.drain_en, bus.done, bus.busy, bus.cmd_ready};
    checks++;
    if (got !== 7'b0000001) begin
      $display("FAIL reset_strobes {fv,fl,ac,de,dn,busy,rdy} got %b want 0000001", got);
      failures++;
    end
    checks++;
    if ((bus.feed_a_addr | bus.feed_b_addr | bus.drain_addr) !== 64'h0) begin
      $display("FAIL reset_addrs got a=%h b=%h d=%h want 0", bus.feed_a_addr, bus.feed_b_addr, bus.drain_addr);
      failures++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      $display("FAIL reset_release rdy=%b busy=%b want rdy=1 busy=0", bus.cmd_ready, bus.busy);
      failures++;
    end
  endtask

  task automatic test_mmul_d;
    issue(1'b0, 64'h100, 64'h200, 64'h300, 11);
    for (int c = 1; c <= 11; c++) begin
      logic [6:0]  got, want;
      logic [63:0] ea, eb, ed;
      got  = {s_fv[c], s_fl[c], s_ac[c], s_de[c], s_dn[c], s_rd[c], s_bz[c]};
      want = {(c == 1 || c == 2), (c == 2), (c == 1), (c == 7 || c == 8), (c == 9), (c >= 10), (c < 10)};
      ea = (c == 1) ? 64'h100 : (c == 2) ? 64'h102 : 64'h0;
      eb = (c == 1) ? 64'h200 : (c == 2) ? 64'h202 : 64'h0;
      ed = (c == 7) ? 64'h300 : (c == 8) ? 64'h302 : 64'h0;
      checks++;
      if (got !== want) begin
        $display("FAIL mmul_d_strobes cycle %0d {fv,fl,ac,de,dn,rdy,busy} got %b want %b", c, got, want);
        failures++;
      end
      checks++;
      if (s_fa[c] !== ea || s_fb[c] !== eb || s_da[c] !== ed) begin
        $display("FAIL mmul_d_addrs cycle %0d got a=%h b=%h d=%h want a=%h b=%h d=%h",
                 c, s_fa[c], s_fb[c], s_da[c], ea, eb, ed);
        failures++;
      end
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = 1'b1;
    bus.cmd_a_addr = 64'h1000;
    bus.cmd_b_addr = 64'h2000;
    bus.cmd_c_addr = 64'h3000;
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk);
      if (c == 10) bus.cmd_op = 1'b0;
      if (c == 17) bus.cmd_valid = 1'b0;
      sample(c);
    end
    for (int c = 1; c <= 27; c++) begin
      logic [3:0]  got, want;
      logic [63:0] ed;
      got  = {s_fv[c], s_ac[c], s_de[c], s_dn[c]};
      want = {(c == 1 || c == 2 || c == 9 || c == 10 || c == 17 || c == 18), (c == 1),
              (c == 23 || c == 24), (c == 7 || c == 15 || c == 25)};
      ed = (c == 23) ? 64'h3000 : (c == 24) ? 64'h3002 : 64'h0;
      checks++;
      if (got !== want || s_da[c] !== ed) begin
        $display("FAIL b2b cycle %0d {fv,ac,de,dn} got %b want %b drain_addr got %h want %h",
                 c, got, want, s_da[c], ed);
        failures++;
      end
    end
  endtask

  task automatic test_settle_hold;
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = 1'b0;
    bus.cmd_a_addr = 64'h100;
    bus.cmd_b_addr = 64'h200;
    bus.cmd_c_addr = 64'h400;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 1) bus.cmd_valid = 1'b0;
      if (c == 4) begin
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = 1'b1;
        bus.cmd_a_addr = 64'h600;
        bus.cmd_b_addr = 64'h700;
        bus.cmd_c_addr = 64'h500;
      end
      if (c == 11) bus.cmd_valid = 1'b0;
      sample(c);
    end
    for (int c = 3; c <= 18; c++) begin
      logic [4:0]  got, want;
      logic [63:0] ea, ed;
      got  = {s_fv[c], s_ac[c], s_de[c], s_dn[c], s_rd[c]};
      want = {(c == 11 || c == 12), (c == 11), (c == 7 || c == 8), (c == 9 || c == 17), (c == 10 || c == 18)};
      ea = (c == 11) ? 64'h600 : (c == 12) ? 64'h602 : 64'h0;
      ed = (c == 7) ? 64'h400 : (c == 8) ? 64'h402 : 64'h0;
      checks++;
      if (got !== want || s_fa[c] !== ea || s_da[c] !== ed) begin
        $display("FAIL settle_hold cycle %0d {fv,ac,de,dn,rdy} got %b want %b a got %h want %h d got %h want %h",
                 c, got, want, s_fa[c], ea, s_da[c], ed);
        failures++;
      end
    end
  endtask

  task automatic test_addr_wrap;
    // Previous command was MMUL_ND, so this first beat must not clear.
    issue(1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h10, 64'h20, 10);
    checks++;
    if (s_fa[1] !== 64'hFFFF_FFFF_FFFF_FFFE || s_fa[2] !== 64'h0) begin
      $display("FAIL addr_wrap a got %h/%h want fffffffffffffffe/0", s_fa[1], s_fa[2]);
      failures++;
    end
    checks++;
    if (s_fb[2] !== 64'h12 || s_ac[1] !== 1'b0 || s_dn[9] !== 1'b1) begin
      $display("FAIL addr_wrap_misc b2 got %h want 12 ac got %b want 0 done got %b want 1",
               s_fb[2], s_ac[1], s_dn[9]);
      failures++;
    end
  endtask

  task automatic test_reset_mid_drain;
    int late_done;
    issue(1'b1, 64'h100, 64'h200, 64'h300, 8);
    issue(1'b0, 64'h100, 64'h200, 64'h800, 7);
    checks++;
    if (s_de[7] !== 1'b1 || s_da[7] !== 64'h800) begin
      $display("FAIL mid_drain_pre de got %b want 1 addr got %h want 800", s_de[7], s_da[7]);
      failures++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.drain_en, bus.done, bus.busy, bus.cmd_ready} !== 4'b0001 || bus.drain_addr !== 64'h0) begin
      $display("FAIL mid_drain_reset {de,dn,busy,rdy} got %b want 0001 addr got %h want 0",
               {bus.drain_en, bus.done, bus.busy, bus.cmd_ready}, bus.drain_addr);
      failures++;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    late_done = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) late_done++;
    end
    checks++;
    if (late_done !== 0) begin
      $display("FAIL mid_drain_no_done got %0d done pulses want 0", late_done);
      failures++;
    end
    issue(1'b0, 64'h100, 64'h200, 64'h300, 10);
    checks++;
    if (s_ac[1] !== 1'b1) begin
      $display("FAIL mid_drain_acc_clear got %b want 1", s_ac[1]);
      failures++;
    end
  endtask

  task automatic test_nd_reset_nd;
    issue(1'b1, 64'h100, 64'h200, 64'h300, 8);
    checks++;
    if (s_ac[1] !== 1'b1 || s_dn[7] !== 1'b1 || s_de[7] !== 1'b0) begin
      $display("FAIL nd_first ac got %b want 1 dn got %b want 1 de got %b want 0", s_ac[1], s_dn[7], s_de[7]);
      failures++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, 64'h100, 64'h200, 64'h300, 8);
    checks++;
    if (s_ac[1] !== 1'b1) begin
      $display("FAIL nd_after_reset ac got %b want 1", s_ac[1]);
      failures++;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_mmul_d();
    test_back_to_back();
    test_settle_hold();
    test_addr_wrap();
    test_reset_mid_drain();
    test_nd_reset_nd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mmul_seq_ctrl.md
# mmul_seq_ctrl

Sequencer for the SYS_ARRAY_SIZE×SYS_ARRAY_SIZE systolic matrix-multiply array. It accepts one command at a time (MMUL_D: multiply then drain; MMUL_ND: multiply and keep partial sums). It then steps the array through feed, wavefront-settle, optional drain and done phases. Along the way it generates operand/result row addresses and the per-PE control strobes. It sits between the command front-end and the operand-feed / drain-writeback logic around the PE grid.

## Interface

Parameters:
- SYS_ARRAY_SIZE, 2: array dimension N; T_C = N, T_D = 2N.
- ADDR_WIDTH, 64: address width of A/B/C base addresses.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  controller can accept a command (high only in IDLE).
- cmd_op_i  in  1  0 = MMUL_D, 1 = MMUL_ND.
- cmd_a_addr_i, cmd_b_addr_i, cmd_c_addr_i  in  ADDR_WIDTH each  base addresses of A, B, C.
- feed_valid_o  out  1  operand row beat valid.
- feed_last_o  out  1  last operand beat; drives matrix_data_t.last.
- feed_a_addr_o, feed_b_addr_o  out  ADDR_WIDTH each  current A/B row address.
- acc_clear_o  out  1  PEs zero their accumulators before this beat.
- drain_en_o  out  1  drain strobe; drives drain_data_t.enable.
- drain_addr_o  out  ADDR_WIDTH  C row address for current drain beat.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse at command completion.

## Operation

- Command latch:
  - Handshake is cmd_valid_i & cmd_ready_o.
  - On handshake, op and the three base addresses are registered; inputs are ignored afterwards.
- States: IDLE → FEED → SETTLE → DRAIN (MMUL_D only) → DONE → IDLE.
- Shared counter: sized $clog2(T_D)+1. It resets to 0 on every state entry.
- IDLE:
  - cmd_ready_o = 1.
  - On handshake, go to FEED.
- FEED (T_C cycles, k = 0..N-1):
  - feed_valid_o = 1.
  - feed_a_addr_o = a_base + k·N and feed_b_addr_o = b_base + k·N.
  - feed_last_o = 1 only at k = N-1.
  - Go to SETTLE after k = N-1.
- SETTLE (T_D cycles): all strobes low; the wavefront propagates through the skewed array.
  - Exit to DRAIN if op = MMUL_D.
  - Exit to DONE if op = MMUL_ND.
- DRAIN (T_C cycles, r = 0..N-1):
  - drain_en_o = 1.
  - drain_addr_o = c_base + r·N.
  - Go to DONE after r = N-1.
- DONE (1 cycle): done_o = 1, then IDLE.
- Accumulate tracking, via a pending_acc register:
  - pending_acc is set at DONE of MMUL_ND and cleared at DONE of MMUL_D.
  - acc_clear_o = 1 on the k = 0 FEED beat iff pending_acc = 0. Consecutive MMUL_ND commands therefore accumulate.
- Address arithmetic: unsigned, modulo 2^ADDR_WIDTH; wrap-around is silent.
- Outputs not named as active in a state are 0. Address outputs are 0 when their strobe is low.

## Timing

- Reset (async assert, any state):
  - State becomes IDLE; counter and pending_acc become 0.
  - Every output is 0 except cmd_ready_o. cmd_ready_o is 1 once rst_n is released.
  - Reset mid-command abandons the command; no done_o is produced.
- Timing is counted from the handshake cycle (cycle 0). All outputs are registered.
- MMUL_D:
  - FEED occupies cycles 1..N and SETTLE cycles N+1..3N.
  - DRAIN occupies 3N+1..4N, with done_o at 4N+1.
  - cmd_ready_o is high again at 4N+2.
- MMUL_ND: done_o at 3N+1; cmd_ready_o high at 3N+2.
- With N = 2:
  - MMUL_D: feed at cycles 1–2, drain at 7–8, done at 9, ready at 10.
  - MMUL_ND: done at 7.
- cmd_valid_i held high while busy is not accepted. It is accepted on the first IDLE cycle, giving back-to-back commands a 1-cycle gap.
- feed_last_o and drain_en_o never overlap. busy_o and cmd_ready_o are always complementary.

## Test plan

- Reset then MMUL_D with N=2, A=0x100, B=0x200, C=0x300:
  - feed at cycles 1–2 with A addresses 0x100/0x102 and B addresses 0x200/0x202.
  - acc_clear_o at cycle 1 only; feed_last_o at cycle 2.
  - drain at cycles 7–8 with addresses 0x300/0x302; done_o at 9.
- MMUL_ND, MMUL_ND, MMUL_D back-to-back (cmd_valid_i held high):
  - acc_clear_o only on the first command's first beat.
  - No drain_en_o for the two ND commands; done at cycles 7, 15, 25.
- cmd_valid_i asserted during SETTLE → no handshake, latched addresses unchanged; accepted the cycle after done_o.
- A base = 2^64-2, N=2 → feed_a_addr_o = 0xFFFF_FFFF_FFFF_FFFE then 0x0.
- rst_n pulsed low in the middle of DRAIN:
  - drain_en_o drops immediately and no done_o follows; pending_acc = 0.
  - The next command asserts acc_clear_o.
- MMUL_ND then reset then MMUL_ND → acc_clear_o asserted on the second command, because reset cleared pending_acc.
